// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: opcodes, FSM states and instruction fields.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_t;

  function automatic logic sets_flags(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL};
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op inside {4'hC, 4'hD, 4'hE};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for cpu_multicycle; LDI/MOV simply pass operand b through.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] wide;

  // Bit DATA_W of the widened result is carry (ADD), borrow (SUB) or the shifted-out msb (SHL).
  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:         wide = {1'b0, a} + {1'b0, b};
      OP_SUB:         wide = {1'b0, a} - {1'b0, b};
      OP_AND:         wide = {1'b0, a & b};
      OP_OR:          wide = {1'b0, a | b};
      OP_XOR:         wide = {1'b0, a ^ b};
      OP_SHL:         wide = {a, 1'b0};
      OP_LDI, OP_MOV: wide = {1'b0, b};
      default:        wide = '0;
    endcase
    result = wide[DATA_W-1:0];
    c      = wide[DATA_W];
    z      = (result == '0);
  end

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle CPU core: 4-entry register file, Z/C flags, IDLE/FETCH/EXEC/HALT control.
// Optional CPU_ILLEGAL_TRAP_EN adds an err output and halts on opcodes C-E.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic [15:0]       ins,
  input  logic              en_ram_out,
  output logic              en_ram_in,
  output logic [ADDR_W-1:0] addr,
  output logic              halt,
  output logic [DATA_W-1:0] reg_out,
  output logic              flag_z,
  output logic              flag_c
`ifdef CPU_ILLEGAL_TRAP_EN
  ,
  output logic              err
`endif
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [4];

  logic [3:0]        op;
  logic [1:0]        rd, rs;
  logic [7:0]        imm;
  logic [DATA_W-1:0] alu_b, alu_result;
  logic              alu_z, alu_c;
  logic              trap, writes_rd, take_jump;

  assign op  = ir[OP_HI:OP_LO];
  assign rd  = ir[RD_HI:RD_LO];
  assign rs  = ir[RS_HI:RS_LO];
  assign imm = ir[IMM_HI:IMM_LO];

`ifdef CPU_ILLEGAL_TRAP_EN
  assign trap = is_illegal(op);
`else
  assign trap = 1'b0;
`endif

  assign alu_b     = (op == OP_LDI) ? DATA_W'(imm) : regs[rs];
  assign writes_rd = op inside {OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_MOV};
  assign take_jump = (op == OP_JMP) || (op == OP_JZ && flag_z) || (op == OP_JC && flag_c);

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (regs[rd]),
    .b      (alu_b),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (en_in) next_state = ST_FETCH;
      ST_FETCH: if (en_ram_out) next_state = ST_EXEC;
      ST_EXEC: begin
        if (op == OP_HLT || trap) next_state = ST_HALT;
        else if (en_in)           next_state = ST_FETCH;
        else                      next_state = ST_IDLE;
      end
      ST_HALT:  next_state = ST_HALT;
      default:  next_state = ST_IDLE;
    endcase
  end

  // PC advances on the fetch handshake, so a taken jump in EXEC overrides the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
`ifdef CPU_ILLEGAL_TRAP_EN
      err    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FETCH: begin
          if (en_ram_out) begin
            ir <= ins;
            pc <= pc + ADDR_W'(1);
          end
        end
        ST_EXEC: begin
          if (!trap) begin
            if (writes_rd) regs[rd] <= alu_result;
            if (sets_flags(op)) begin
              flag_z <= alu_z;
              flag_c <= alu_c;
            end
            if (take_jump) pc <= ADDR_W'(imm);
          end
`ifdef CPU_ILLEGAL_TRAP_EN
          if (trap) err <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign en_ram_in = (state == ST_FETCH);
  assign addr      = pc;
  assign halt      = (state == ST_HALT);
  assign reg_out   = regs[0];

endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench for cpu_multicycle: a 16-bit core and an 8-bit core (RESET_PC=0xFFFE)
// share stimulus; whichever is not selected is held in reset.
module tb_cpu_multicycle;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, en_in, en_ram_out, sel;
  logic [15:0] ins;

  logic        req_a, halt_a, z_a, c_a;
  logic [15:0] addr_a, reg_a;
  logic        req_b, halt_b, z_b, c_b;
  logic [15:0] addr_b;
  logic [7:0]  reg_b;
`ifdef CPU_ILLEGAL_TRAP_EN
  logic        err_a, err_b;
`endif

  logic        obs_req, obs_halt, obs_z, obs_c, obs_err;
  logic [15:0] obs_addr, obs_reg;

  int tests_run = 0;
  int failures  = 0;

  logic [15:0] m_regs [4];
  logic [15:0] m_pc;
  logic        m_z, m_c, m_halt, m_err, m_req;

  always #5 clk = ~clk;

  cpu_multicycle dut_a (
    .clk(clk), .rst(rst_a), .en_in(en_in), .ins(ins), .en_ram_out(en_ram_out),
    .en_ram_in(req_a), .addr(addr_a), .halt(halt_a), .reg_out(reg_a),
    .flag_z(z_a), .flag_c(c_a)
`ifdef CPU_ILLEGAL_TRAP_EN
    , .err(err_a)
`endif
  );

  cpu_multicycle #(.DATA_W(8), .ADDR_W(16), .RESET_PC(16'hFFFE)) dut_b (
    .clk(clk), .rst(rst_b), .en_in(en_in), .ins(ins), .en_ram_out(en_ram_out),
    .en_ram_in(req_b), .addr(addr_b), .halt(halt_b), .reg_out(reg_b),
    .flag_z(z_b), .flag_c(c_b)
`ifdef CPU_ILLEGAL_TRAP_EN
    , .err(err_b)
`endif
  );

  always_comb begin
    obs_req  = sel ? req_b  : req_a;
    obs_addr = sel ? addr_b : addr_a;
    obs_halt = sel ? halt_b : halt_a;
    obs_reg  = sel ? {8'h00, reg_b} : reg_a;
    obs_z    = sel ? z_b : z_a;
    obs_c    = sel ? c_b : c_a;
`ifdef CPU_ILLEGAL_TRAP_EN
    obs_err  = sel ? err_b : err_a;
`else
    obs_err  = 1'b0;
`endif
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkCore();
    checkOutput("reg_out", obs_reg, m_regs[0]);
    checkOutput("flag_z", obs_z, m_z);
    checkOutput("flag_c", obs_c, m_c);
    checkOutput("halt", obs_halt, m_halt);
    checkOutput("en_ram_in", obs_req, m_req);
    checkOutput("addr", obs_addr, m_pc);
`ifdef CPU_ILLEGAL_TRAP_EN
    checkOutput("err", obs_err, m_err);
`endif
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_pc   = sel ? 16'hFFFE : 16'h0000;
    m_z    = 1'b0;
    m_c    = 1'b0;
    m_halt = 1'b0;
    m_err  = 1'b0;
    m_req  = 1'b0;
  endtask

  // Instruction-level reference: one call = one architectural instruction.
  task automatic modelExec(input logic [15:0] instr, input logic en_after);
    int unsigned mask, a, b, full;
    logic [3:0]  op;
    int          rd, rs;
    logic [15:0] imm;
    logic        upd;
    mask = sel ? 32'hFF : 32'hFFFF;
    op   = instr[15:12];
    rd   = int'(instr[11:10]);
    rs   = int'(instr[9:8]);
    imm  = {8'h00, instr[7:0]};
    a    = m_regs[rd];
    b    = m_regs[rs];
    full = 0;
    upd  = 1'b0;
    m_pc = m_pc + 16'd1;
    case (op)
      4'h1: m_regs[rd] = imm;
      4'h2: begin full = a + b; m_c = (full > mask); upd = 1'b1; end
      4'h3: begin full = a - b; m_c = (a < b);       upd = 1'b1; end
      4'h4: begin full = a & b; m_c = 1'b0;          upd = 1'b1; end
      4'h5: begin full = a | b; m_c = 1'b0;          upd = 1'b1; end
      4'h6: begin full = a ^ b; m_c = 1'b0;          upd = 1'b1; end
      4'h7: begin full = a * 2; m_c = (full > mask); upd = 1'b1; end
      4'h8: m_regs[rd] = b[15:0];
      4'h9: m_pc = imm;
      4'hA: if (m_z) m_pc = imm;
      4'hB: if (m_c) m_pc = imm;
`ifdef CPU_ILLEGAL_TRAP_EN
      4'hC, 4'hD, 4'hE: begin m_err = 1'b1; m_halt = 1'b1; end
`endif
      4'hF: m_halt = 1'b1;
      default: ;
    endcase
    if (upd) begin
      full = full & mask;
      m_regs[rd] = full[15:0];
      m_z = (full == 0);
    end
    m_req = en_after && !m_halt;
  endtask

  // Reset is asserted while a fetch handshake is offered, so it must win over the load.
  task automatic applyReset();
    @(negedge clk);
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    en_ram_out = 1'b1;
    ins        = 16'h1055;
    @(posedge clk);
    @(negedge clk);
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    en_ram_out = 1'b0;
    modelReset();
    checkCore();
  endtask

  // Call at a negedge; serves one fetch after 'waits' stall cycles, ends at the negedge after EXEC.
  task automatic applyStimulus(input logic [15:0] instr, input int waits, input logic en_after);
    int n;
    en_in = 1'b1;
    n = 0;
    while (obs_req !== 1'b1 && n < 8) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checkOutput("fetch_req", obs_req, 1);
    if (obs_req !== 1'b1) return;
    for (int w = 0; w < waits; w++) begin
      en_ram_out = 1'b0;
      ins        = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      checkOutput("wait_req", obs_req, 1);
      checkOutput("wait_addr", obs_addr, m_pc);
      checkOutput("wait_reg", obs_reg, m_regs[0]);
    end
    checkOutput("fetch_addr", obs_addr, m_pc);
    en_ram_out = 1'b1;
    ins        = instr;
    @(posedge clk);
    @(negedge clk);
    en_ram_out = 1'($urandom);
    ins        = 16'($urandom);
    en_in      = en_after;
    modelExec(instr, en_after);
    @(posedge clk);
    @(negedge clk);
    checkCore();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] instr;
    sel        = 1'b0;
    rst_a      = 1'b1;
    rst_b      = 1'b1;
    en_in      = 1'b0;
    en_ram_out = 1'b0;
    ins        = '0;
    modelReset();
    repeat (2) @(posedge clk);

    applyReset();

    applyStimulus(16'h1001, 0, 1'b1);
    applyStimulus(16'h1402, 0, 1'b1);
    applyStimulus(16'h2100, 0, 1'b1);

    applyStimulus(16'h3000, 0, 1'b1);
    applyStimulus(16'hA0C2, 0, 1'b1);
    applyStimulus(16'h2100, 0, 1'b1);
    applyStimulus(16'hA0C2, 0, 1'b1);

    applyStimulus(16'h1023, 5, 1'b1);

    applyStimulus(16'h1001, 0, 1'b1);
    applyStimulus(16'h3100, 0, 1'b1);
    applyStimulus(16'hB040, 1, 1'b1);
    applyStimulus(16'h8400, 0, 1'b0);
    applyStimulus(16'h7000, 2, 1'b1);

    applyReset();

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 14));
`ifdef CPU_ILLEGAL_TRAP_EN
      if (op inside {4'hC, 4'hD, 4'hE}) op = 4'h0;
`endif
      instr = {op, 12'($urandom)};
      applyStimulus(instr, $urandom_range(0, 2), 1'($urandom));
    end

    applyStimulus(16'hF000, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      en_in      = 1'b1;
      en_ram_out = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("halt_hold", obs_halt, m_halt);
      checkOutput("halt_req", obs_req, m_req);
    end
    applyReset();

`ifdef CPU_ILLEGAL_TRAP_EN
    applyStimulus(16'h1007, 0, 1'b1);
    applyStimulus(16'hC000, 0, 1'b1);
    applyReset();
`endif

    sel   = 1'b1;
    rst_a = 1'b1;
    applyReset();
    applyStimulus(16'h10FF, 0, 1'b1);
    applyStimulus(16'h1401, 0, 1'b1);
    applyStimulus(16'h2100, 0, 1'b1);
    applyStimulus(16'h1081, 1, 1'b1);
    applyStimulus(16'h7000, 0, 1'b1);
    applyStimulus(16'h3100, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
